// File: rtl/bram_req_bridge.sv
// Single-outstanding CPU request bridge onto a word BRAM with split read (ar/r) and write (aw/w/b) channels.
// Optional wait-state timeout is built only when BRAM_BRIDGE_TIMEOUT_EN is defined.
module bram_req_bridge #(
   parameter int          ADDR_WIDTH     = 15,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [3:0]            req_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_arvalid,
   output logic [ADDR_WIDTH-1:0] mem_araddr,
   input  logic                  mem_arready,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_rvalid,
   output logic                  mem_rready,
   output logic                  mem_awvalid,
   output logic [ADDR_WIDTH-1:0] mem_awaddr,
   input  logic                  mem_awready,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_wstrb,
   output logic                  mem_wvalid,
   input  logic                  mem_wready,
   input  logic                  mem_bvalid,
   output logic                  mem_bready
);

   // state   | meaning
   // IDLE    | waiting for a CPU request
   // RD_ADDR | read address offered, read data also accepted
   // RD_DATA | address taken, waiting for read data
   // WR      | write address and data offered together
   // WR_RESP | both accepted, waiting for write response
   // RESP    | response held for the CPU
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic                  b_seen;
   logic                  aw_acc;
   logic                  w_acc;
   logic                  unused_addr_bits;

`ifdef BRAM_BRIDGE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt;
`endif

   assign req_ready        = (state == IDLE) && !rst;
   assign mem_araddr       = word_addr;
   assign mem_awaddr       = word_addr;
   assign unused_addr_bits = ^req_addr[1:0];

   // A channel whose valid has already dropped counts as accepted.
   assign aw_acc = !mem_awvalid || mem_awready;
   assign w_acc  = !mem_wvalid  || mem_wready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         word_addr   <= '0;
         b_seen      <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         mem_arvalid <= 1'b0;
         mem_rready  <= 1'b0;
         mem_awvalid <= 1'b0;
         mem_wvalid  <= 1'b0;
         mem_bready  <= 1'b0;
         mem_wdata   <= '0;
         mem_wstrb   <= '0;
`ifdef BRAM_BRIDGE_TIMEOUT_EN
         tmo_cnt     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef BRAM_BRIDGE_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               if (req_valid) begin
                  word_addr <= req_addr[ADDR_WIDTH+1:2];
                  mem_wdata <= req_wdata;
                  mem_wstrb <= req_wstrb;
                  b_seen    <= 1'b0;
                  if (req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else if (req_we) begin
                     state       <= WR;
                     mem_awvalid <= 1'b1;
                     mem_wvalid  <= 1'b1;
                     mem_bready  <= 1'b1;
                  end else begin
                     state       <= RD_ADDR;
                     mem_arvalid <= 1'b1;
                     mem_rready  <= 1'b1;
                  end
               end
            end
            RD_ADDR: begin
               if (mem_arready) begin
                  mem_arvalid <= 1'b0;
                  if (mem_rvalid) begin
                     state      <= RESP;
                     mem_rready <= 1'b0;
                     rsp_valid  <= 1'b1;
                     rsp_rdata  <= mem_rdata;
                     rsp_err    <= 1'b0;
                  end else begin
                     state <= RD_DATA;
                  end
               end
            end
            RD_DATA: begin
               if (mem_rvalid) begin
                  state      <= RESP;
                  mem_rready <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_rdata  <= mem_rdata;
                  rsp_err    <= 1'b0;
               end
            end
            WR: begin
               if (mem_awready) mem_awvalid <= 1'b0;
               if (mem_wready)  mem_wvalid  <= 1'b0;
               if (mem_bvalid)  b_seen      <= 1'b1;
               if (aw_acc && w_acc) begin
                  mem_awvalid <= 1'b0;
                  mem_wvalid  <= 1'b0;
                  if (b_seen || mem_bvalid) begin
                     state      <= RESP;
                     mem_bready <= 1'b0;
                     rsp_valid  <= 1'b1;
                     rsp_rdata  <= '0;
                     rsp_err    <= 1'b0;
                  end else begin
                     state <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               if (mem_bvalid) begin
                  state      <= RESP;
                  mem_bready <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_rdata  <= '0;
                  rsp_err    <= 1'b0;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= '0;
               end
            end
            default: state <= IDLE;
         endcase

`ifdef BRAM_BRIDGE_TIMEOUT_EN
         // Overrides any same-cycle progress so the abort is unconditional.
         if (state inside {RD_ADDR, RD_DATA, WR, WR_RESP}) begin
            if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               state       <= RESP;
               mem_arvalid <= 1'b0;
               mem_rready  <= 1'b0;
               mem_awvalid <= 1'b0;
               mem_wvalid  <= 1'b0;
               mem_bready  <= 1'b0;
               rsp_valid   <= 1'b1;
               rsp_rdata   <= '0;
               rsp_err     <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: doc/bram_req_bridge.md
Name: bram_req_bridge

Overview:
- Sits between the CPU data/instruction port and the 32-bit word BRAM.
- Converts one outstanding CPU request (valid/ready, byte address) into the BRAM read channel (ar/r) or write channel (aw/w/b).
- Holds the response stable until the CPU takes it.
- Range-checks addresses and returns an error without touching memory on a miss.

Parameters:
- ADDR_WIDTH, 15: BRAM word-address width (2^15 words = 128 KiB window).
- BASE_ADDR, 32'h0000_0000: byte base of the window; only bits [31:ADDR_WIDTH+2] are compared.
- TIMEOUT_CYCLES, 64: wait-state limit; used only with BRAM_BRIDGE_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  bridge accepts request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  write data
- req_wstrb  in  4  byte enables
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  CPU takes response
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_err  out  1  out-of-range or timeout
- mem_arvalid  out  1  read address valid
- mem_araddr  out  ADDR_WIDTH  word address
- mem_arready  in  1  read address accepted
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data pulse
- mem_rready  out  1  read data ready
- mem_awvalid  out  1  write address valid
- mem_awaddr  out  ADDR_WIDTH  word address
- mem_awready  in  1  write address accepted
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte enables
- mem_wvalid  out  1  write data valid
- mem_wready  in  1  write data accepted
- mem_bvalid  in  1  write response pulse
- mem_bready  out  1  write response ready

Behaviour:
- Reset: state IDLE; all outputs 0 while rst is high, including req_ready.
- Reset mid-transaction: drop all valids next cycle and discard pending data/response.
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP.
- req_ready = (state == IDLE) and not rst.
- IDLE, on req_valid: register addr, wdata, wstrb and we.
  - Out of range (req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]): go to RESP with rsp_err = 1 and rsp_rdata = 0. No mem_* valid is asserted.
  - Otherwise: read goes to RD_ADDR; write goes to WR.
- Word address: mem_araddr = mem_awaddr = addr[ADDR_WIDTH+1:2].
- RD_ADDR:
  - mem_arvalid = 1 and mem_rready = 1.
  - mem_arready drops mem_arvalid on the next edge.
  - mem_rvalid in the same cycle as mem_arready: capture mem_rdata and go to RESP.
  - mem_arready without mem_rvalid: go to RD_DATA.
- RD_DATA: mem_rready = 1; on mem_rvalid, capture mem_rdata and go to RESP.
- WR:
  - mem_awvalid and mem_wvalid are asserted together.
  - Each one drops on its own ready.
  - mem_bready = 1 throughout.
  - Once both are accepted: go to RESP if mem_bvalid was seen (it may coincide), else go to WR_RESP.
- WR_RESP: mem_bready = 1; on mem_bvalid go to RESP.
- Memory returns ready and response one cycle after valid. The bridge therefore keeps its valid for one extra cycle, which produces a duplicate idempotent access and a stray mem_rvalid/mem_bvalid pulse. Pulses arriving in RESP or IDLE are ignored.
- RESP: rsp_valid = 1, with rsp_rdata and rsp_err stable; on rsp_ready go to IDLE next cycle.
- Latency (req accept -> rsp_valid): read 2 cycles, write 2 cycles, range error 1 cycle.
- Back-to-back: minimum 1 IDLE cycle between transactions.

Optional Feature:
- BRAM_BRIDGE_TIMEOUT_EN defined:
  - A counter ($clog2(TIMEOUT_CYCLES+1) bits) clears on entry to RD_ADDR or WR and increments in RD_ADDR, RD_DATA, WR and WR_RESP.
  - When it reaches TIMEOUT_CYCLES: drop all mem_* valids and go to RESP with rsp_err = 1 and rsp_rdata = 0.
- Not defined: no counter is built; wait states persist indefinitely.

Test Plan:
- Write 0x0000_0010, wdata 0xA5A5_1234, wstrb 0xF, then read 0x0000_0010 -> mem_awaddr = 4; rsp_rdata = 0xA5A5_1234, rsp_err = 0, rsp_valid 2 cycles after accept.
- Preload word 4 = 0x1122_3344; write 0x0000_0010, wdata 0x0000_FF00, wstrb 0x2; read back -> 0x1122_FF44 (duplicate write harmless).
- Read 0x0002_0000 with defaults -> rsp_err = 1, rsp_rdata = 0, no mem_arvalid ever asserted, rsp_valid 1 cycle after accept.
- Read with rsp_ready low for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready = 0, no new mem_arvalid; IDLE one cycle after rsp_ready.
- Assert rst for 1 cycle while in RD_DATA -> all valids 0 next cycle, no rsp_valid; a subsequent read returns correct data.
- With BRAM_BRIDGE_TIMEOUT_EN, memory stub never asserts mem_arready -> rsp_err = 1 exactly 64 cycles after entering RD_ADDR; mem_arvalid 0 thereafter.
